// File: rtl/clk_div_sched.sv
// Programmable clock-enable divider with a two-client, round-robin ratio scheduler.
// New ratios take effect only at a period boundary, so no runt or stretched period is produced.
module clk_div_sched #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [CNT_W-1:0] div_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [CNT_W-1:0] div_b,
    output logic             ack_b,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             clk_en,
    output logic             div_out
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitTc,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);
    localparam logic [CNT_W-1:0] Two    = CNT_W'(2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             gnt_b_q, gnt_b_d;
    logic             ptr_b_q, ptr_b_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             err_q, err_d;
    logic             clk_en_q, clk_en_d;
    logic             div_out_q, div_out_d;

    logic             terminal;
    logic             sel_b;
    logic [CNT_W-1:0] sel_div;
    logic             gnt_req;

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        gnt_b_d    = gnt_b_q;
        ptr_b_d    = ptr_b_q;
        ack_a_d    = ack_a_q;
        ack_b_d    = ack_b_q;
        err_d      = err_q;
        sel_b      = 1'b0;
        sel_div    = div_a;
        gnt_req    = 1'b0;

        terminal = (cnt_q == (cur_div_q - One));
        cnt_d    = terminal ? '0 : (cnt_q + One);

        unique case (state_q)
            StIdle: begin
                if (req_a || req_b) begin
                    // B wins when it is alone or when both ask and the pointer is at B
                    sel_b      = req_b && (!req_a || ptr_b_q);
                    sel_div    = sel_b ? div_b : div_a;
                    gnt_b_d    = sel_b;
                    ptr_b_d    = !sel_b;
                    pend_div_d = sel_div;
                    if (sel_div < Two) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        ack_a_d = !sel_b;
                        ack_b_d = sel_b;
                    end else begin
                        state_d = StWaitTc;
                    end
                end
            end
            StWaitTc: begin
                if (terminal) begin
                    cur_div_d = pend_div_q;
                    state_d   = StDone;
                    ack_a_d   = !gnt_b_q;
                    ack_b_d   = gnt_b_q;
                end
            end
            StDone: begin
                gnt_req = gnt_b_q ? req_b : req_a;
                if (!gnt_req) begin
                    ack_a_d = 1'b0;
                    ack_b_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered from next-state values so the outputs line up with the new count
        clk_en_d  = (cnt_d == (cur_div_d - One));
        div_out_d = (cnt_d < (cur_div_d >> 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_div_q  <= DefDiv;
            pend_div_q <= DefDiv;
            gnt_b_q    <= 1'b0;
            ptr_b_q    <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_q      <= 1'b0;
            clk_en_q   <= 1'b0;
            div_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            gnt_b_q    <= gnt_b_d;
            ptr_b_q    <= ptr_b_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            err_q      <= err_d;
            clk_en_q   <= clk_en_d;
            div_out_q  <= div_out_d;
        end
    end

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign err     = err_q;
    assign busy    = (state_q != StIdle);
    assign cur_div = cur_div_q;
    assign clk_en  = clk_en_q;
    assign div_out = div_out_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: reset cadence, ratio switches, arbitration, rejects,
// asynchronous reset mid-handshake and the widest ratio.
module tb_clk_div_sched;

    logic       clk;
    logic       reset;
    logic       req_a;
    logic [7:0] div_a;
    logic       ack_a;
    logic       req_b;
    logic [7:0] div_b;
    logic       ack_b;
    logic       err;
    logic       busy;
    logic [7:0] cur_div;
    logic       clk_en;
    logic       div_out;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_sched #(
        .CNT_W      (8),
        .DEFAULT_DIV(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req_a),
        .div_a  (div_a),
        .ack_a  (ack_a),
        .req_b  (req_b),
        .div_b  (div_b),
        .ack_b  (ack_b),
        .err    (err),
        .busy   (busy),
        .cur_div(cur_div),
        .clk_en (clk_en),
        .div_out(div_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for either ack; reports edges taken and clk_en of the sample before the ack.
    task automatic wait_ack(input int bound, output int lat, output bit seen, output logic prev_en);
        seen    = 1'b0;
        lat     = 0;
        prev_en = clk_en;
        while (!seen && lat < bound) begin
            prev_en = clk_en;
            tick();
            lat++;
            if (ack_a || ack_b) seen = 1'b1;
        end
    endtask

    // Measures one full period between clk_en pulses and the div_out high count within it.
    task automatic measure_period(output int period, output int highs, output bit ok);
        ok     = 1'b0;
        period = 0;
        highs  = 0;
        for (int i = 0; i < 600 && !clk_en; i++) tick();
        if (clk_en) begin
            for (int i = 0; i < 600; i++) begin
                tick();
                period++;
                if (div_out) highs++;
                if (clk_en) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic exp_en[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic exp_do[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        div_a = 8'd0;
        div_b = 8'd0;
        #3;
        n_checks++; if (cur_div !== 8'd3) begin n_fail++; $display("FAIL rst_cur_div: got %0d expected 3", cur_div); end
        n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL rst_clk_en: got %b expected 0", clk_en); end
        n_checks++; if (div_out !== 1'b0) begin n_fail++; $display("FAIL rst_div_out: got %b expected 0", div_out); end
        n_checks++; if ({ack_a, ack_b, err, busy} !== 4'b0000) begin n_fail++; $display("FAIL rst_ctl: got %b expected 0000", {ack_a, ack_b, err, busy}); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++; if (clk_en !== exp_en[i]) begin n_fail++; $display("FAIL rst_cad_en[%0d]: got %b expected %b", i, clk_en, exp_en[i]); end
            n_checks++; if (div_out !== exp_do[i]) begin n_fail++; $display("FAIL rst_cad_do[%0d]: got %b expected %b", i, div_out, exp_do[i]); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy[%0d]: got %b expected 0", i, busy); end
        end
    endtask

    task automatic test_switch_a();
        int   lat, per, hi;
        bit   seen, ok;
        logic pen;
        req_a = 1'b1;
        div_a = 8'd4;
        wait_ack(10, lat, seen, pen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL sw_ack_seen: got %b expected 1", seen); end
        n_checks++; if (lat > 4) begin n_fail++; $display("FAIL sw_latency: got %0d expected <= 4", lat); end
        n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL sw_ack_a: got %b expected 1", ack_a); end
        n_checks++; if (cur_div !== 8'd4) begin n_fail++; $display("FAIL sw_cur_div: got %0d expected 4", cur_div); end
        n_checks++; if ({pen, clk_en, div_out} !== 3'b101) begin n_fail++; $display("FAIL sw_align: got %b expected 101", {pen, clk_en, div_out}); end
        n_checks++; if ({err, ack_b, busy} !== 3'b001) begin n_fail++; $display("FAIL sw_ctl: got %b expected 001", {err, ack_b, busy}); end
        measure_period(per, hi, ok);
        n_checks++; if (ok !== 1'b1 || per != 4) begin n_fail++; $display("FAIL sw_period: got %0d expected 4", per); end
        n_checks++; if (hi != 2) begin n_fail++; $display("FAIL sw_high: got %0d expected 2", hi); end
        n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL sw_ack_hold: got %b expected 1", ack_a); end
        req_a = 1'b0;
        tick();
        n_checks++; if ({ack_a, busy} !== 2'b00) begin n_fail++; $display("FAIL sw_release: got %b expected 00", {ack_a, busy}); end
    endtask

    task automatic test_arbitration();
        int   lat, per, hi;
        bit   seen, ok;
        logic pen;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_a = 1'b1;
        div_a = 8'd5;
        req_b = 1'b1;
        div_b = 8'd6;
        wait_ack(10, lat, seen, pen);
        n_checks++; if ({seen, ack_a, ack_b} !== 3'b110) begin n_fail++; $display("FAIL arb1_acks: got %b expected 110", {seen, ack_a, ack_b}); end
        n_checks++; if (cur_div !== 8'd5) begin n_fail++; $display("FAIL arb1_cur_div: got %0d expected 5", cur_div); end
        n_checks++; if (pen !== 1'b1 || clk_en !== 1'b0) begin n_fail++; $display("FAIL arb1_align: got %b%b expected 10", pen, clk_en); end
        req_a = 1'b0;
        tick();
        n_checks++; if ({ack_a, ack_b} !== 2'b00) begin n_fail++; $display("FAIL arb1_release: got %b expected 00", {ack_a, ack_b}); end
        wait_ack(12, lat, seen, pen);
        n_checks++; if ({seen, ack_a, ack_b} !== 3'b101) begin n_fail++; $display("FAIL arb2_acks: got %b expected 101", {seen, ack_a, ack_b}); end
        n_checks++; if (cur_div !== 8'd6) begin n_fail++; $display("FAIL arb2_cur_div: got %0d expected 6", cur_div); end
        n_checks++; if (pen !== 1'b1 || clk_en !== 1'b0) begin n_fail++; $display("FAIL arb2_align: got %b%b expected 10", pen, clk_en); end
        measure_period(per, hi, ok);
        n_checks++; if (ok !== 1'b1 || per != 6 || hi != 3) begin n_fail++; $display("FAIL arb2_period: got %0d/%0d expected 6/3", per, hi); end
        req_b = 1'b0;
        tick();
        n_checks++; if ({ack_b, busy} !== 2'b00) begin n_fail++; $display("FAIL arb2_release: got %b expected 00", {ack_b, busy}); end
        // Pointer is back at A after serving A then B
        req_a = 1'b1;
        div_a = 8'd4;
        req_b = 1'b1;
        div_b = 8'd7;
        wait_ack(10, lat, seen, pen);
        n_checks++; if ({seen, ack_a, ack_b} !== 3'b110) begin n_fail++; $display("FAIL arb3_acks: got %b expected 110", {seen, ack_a, ack_b}); end
        n_checks++; if (cur_div !== 8'd4) begin n_fail++; $display("FAIL arb3_cur_div: got %0d expected 4", cur_div); end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        n_checks++; if ({ack_a, busy} !== 2'b00) begin n_fail++; $display("FAIL arb3_release: got %b expected 00", {ack_a, busy}); end
        // Pointer now at B
        req_a = 1'b1;
        div_a = 8'd2;
        req_b = 1'b1;
        div_b = 8'd5;
        wait_ack(10, lat, seen, pen);
        n_checks++; if ({seen, ack_a, ack_b} !== 3'b101) begin n_fail++; $display("FAIL arb4_acks: got %b expected 101", {seen, ack_a, ack_b}); end
        n_checks++; if (cur_div !== 8'd5) begin n_fail++; $display("FAIL arb4_cur_div: got %0d expected 5", cur_div); end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        n_checks++; if ({ack_b, busy} !== 2'b00) begin n_fail++; $display("FAIL arb4_release: got %b expected 00", {ack_b, busy}); end
    endtask

    task automatic test_reject();
        int cnt;
        for (int i = 0; i < 10 && !clk_en; i++) tick();
        req_b = 1'b1;
        div_b = 8'd1;
        tick();
        cnt = 1;
        n_checks++; if ({ack_b, err, ack_a, busy} !== 4'b1101) begin n_fail++; $display("FAIL rej1_ctl: got %b expected 1101", {ack_b, err, ack_a, busy}); end
        n_checks++; if (cur_div !== 8'd5) begin n_fail++; $display("FAIL rej1_cur_div: got %0d expected 5", cur_div); end
        for (int i = 0; i < 10 && !clk_en; i++) begin
            tick();
            cnt++;
        end
        n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL rej1_cadence: got %0d expected 5", cnt); end
        req_b = 1'b0;
        tick();
        n_checks++; if ({ack_b, err, busy} !== 3'b000) begin n_fail++; $display("FAIL rej1_release: got %b expected 000", {ack_b, err, busy}); end
        req_b = 1'b1;
        div_b = 8'd0;
        tick();
        n_checks++; if ({ack_b, err} !== 2'b11) begin n_fail++; $display("FAIL rej0_ctl: got %b expected 11", {ack_b, err}); end
        n_checks++; if (cur_div !== 8'd5) begin n_fail++; $display("FAIL rej0_cur_div: got %0d expected 5", cur_div); end
        req_b = 1'b0;
        tick();
        n_checks++; if ({ack_b, err, busy} !== 3'b000) begin n_fail++; $display("FAIL rej0_release: got %b expected 000", {ack_b, err, busy}); end
    endtask

    task automatic test_async_reset();
        req_a = 1'b1;
        div_a = 8'd7;
        tick();
        n_checks++; if ({busy, ack_a} !== 2'b10) begin n_fail++; $display("FAIL ars_wait: got %b expected 10", {busy, ack_a}); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, ack_a, ack_b, err, clk_en, div_out} !== 6'b000000) begin n_fail++; $display("FAIL ars_clear: got %b expected 000000", {busy, ack_a, ack_b, err, clk_en, div_out}); end
        n_checks++; if (cur_div !== 8'd3) begin n_fail++; $display("FAIL ars_cur_div: got %0d expected 3", cur_div); end
        req_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if ({busy, ack_a} !== 2'b00 || cur_div !== 8'd3) begin n_fail++; $display("FAIL ars_after: got %b/%0d expected 00/3", {busy, ack_a}, cur_div); end
    endtask

    task automatic test_max_ratio();
        int   lat, per, hi;
        bit   seen, ok;
        logic pen;
        req_a = 1'b1;
        div_a = 8'd255;
        wait_ack(10, lat, seen, pen);
        n_checks++; if ({seen, ack_a} !== 2'b11) begin n_fail++; $display("FAIL max_ack: got %b expected 11", {seen, ack_a}); end
        n_checks++; if (cur_div !== 8'd255) begin n_fail++; $display("FAIL max_cur_div: got %0d expected 255", cur_div); end
        n_checks++; if ({pen, clk_en, div_out} !== 3'b101) begin n_fail++; $display("FAIL max_align: got %b expected 101", {pen, clk_en, div_out}); end
        measure_period(per, hi, ok);
        n_checks++; if (ok !== 1'b1 || per != 255) begin n_fail++; $display("FAIL max_period: got %0d expected 255", per); end
        n_checks++; if (hi != 127) begin n_fail++; $display("FAIL max_high: got %0d expected 127", hi); end
        req_a = 1'b0;
        tick();
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL max_release: got %b expected 0", ack_a); end
        req_a = 1'b1;
        div_a = 8'd2;
        wait_ack(300, lat, seen, pen);
        n_checks++; if ({seen, ack_a} !== 2'b11 || lat > 256) begin n_fail++; $display("FAIL min_ack: got %b lat %0d expected 11 lat <= 256", {seen, ack_a}, lat); end
        n_checks++; if (cur_div !== 8'd2) begin n_fail++; $display("FAIL min_cur_div: got %0d expected 2", cur_div); end
        n_checks++; if ({pen, clk_en, div_out} !== 3'b101) begin n_fail++; $display("FAIL min_align: got %b expected 101", {pen, clk_en, div_out}); end
        measure_period(per, hi, ok);
        n_checks++; if (ok !== 1'b1 || per != 2 || hi != 1) begin n_fail++; $display("FAIL min_period: got %0d/%0d expected 2/1", per, hi); end
        req_a = 1'b0;
        tick();
        n_checks++; if ({ack_a, busy} !== 2'b00) begin n_fail++; $display("FAIL min_release: got %b expected 00", {ack_a, busy}); end
    endtask

    initial begin
        test_reset();
        test_switch_a();
        test_arbitration();
        test_reject();
        test_async_reset();
        test_max_ratio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Programmable integer clock-enable divider with a two-requester divide-ratio scheduler. Two clients (A, B) request new divide ratios over 4-phase req/ack handshakes. A round-robin arbiter grants one request at a time. The new ratio is applied only at the terminal count of the current period, so no runt or stretched period is ever produced. The block sits beside the fixed clock dividers and drives clk_en and div_out to downstream logic in the same clk domain.

Parameters:
CNT_W, 8, width of the counter and of the divide-ratio fields.
DEFAULT_DIV, 3, divide ratio loaded at reset. Must be between 2 and 2^CNT_W-1.

Ports:
clk  input  1  system clock; all logic is posedge.
reset  input  1  asynchronous, active-high reset.
req_a  input  1  request from client A; level, 4-phase.
div_a  input  CNT_W  ratio requested by A; must be stable while req_a is high.
ack_a  output  1  acknowledge to A.
req_b  input  1  request from client B; level, 4-phase.
div_b  input  CNT_W  ratio requested by B.
ack_b  output  1  acknowledge to B.
err  output  1  ratio rejected; valid while either ack is high.
busy  output  1  scheduler not in IDLE.
cur_div  output  CNT_W  currently applied ratio.
clk_en  output  1  one-cycle pulse per divided period.
div_out  output  1  divided waveform; high floor(cur_div/2) cycles per period.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - cnt=0, cur_div=DEFAULT_DIV, state=IDLE.
  - ack_a=ack_b=err=0, clk_en=0, div_out=0, priority pointer=A.
- Counter: on each posedge, cnt_next = (cnt==cur_div-1) ? 0 : cnt+1. The terminal cycle is the cycle where cnt==cur_div-1.
- clk_en and div_out are flops:
  - clk_en <= (cnt_next == cur_div_next-1).
  - div_out <= (cnt_next < (cur_div_next>>1)).
  - Both are glitch-free. Period is exactly cur_div cycles.
- FSM states: IDLE, WAIT_TC, DONE. busy = (state != IDLE).
- IDLE:
  - Sample req_a and req_b.
  - If only one is high, grant it. If both are high, grant the client at the priority pointer; on every grant the pointer moves to the other client.
  - On grant, latch the requested div into pend_div and the grantee ID.
  - If div < 2: go to DONE with err=1; cur_div and the counter are untouched.
  - Otherwise go to WAIT_TC.
- WAIT_TC:
  - At the first terminal-cycle edge strictly after the grant edge: cur_div <= pend_div, cnt <= 0, go to DONE.
  - The grantee's ack rises at that same edge.
  - Worst-case req-to-ack latency: old cur_div + 1 cycles.
- DONE:
  - The grantee's ack stays high (err held if rejected) until the grantee's req is sampled low.
  - Then ack and err clear and the FSM returns to IDLE.
  - Earliest next grant is the following edge.
- Non-granted request: held pending with no ack while the other client is served. Its div value is sampled only at its own grant.
- Request dropped before ack (protocol violation): the switch still completes; DONE exits as soon as req is sampled low.
- Max ratio 2^CNT_W-1 gives cnt range 0..2^CNT_W-2; there is no arithmetic overflow.
- cur_div changes only at a period boundary. clk_en cadence is never interrupted by arbitration or rejection.

Test Plan:
1. Reset, DEFAULT_DIV=3, no requests -> cnt goes 1,2,0,...; clk_en high every 3rd cycle (first at 2nd edge after release); div_out high 1 of 3 cycles; busy=0.
2. req_a with div_a=4 while cur_div=3 -> ack_a rises at the next terminal edge. From then on, period is 4, div_out is high 2 of 4, cur_div=4. ack_a falls one edge after req_a drops.
3. req_a (div 5) and req_b (div 6) raised on the same cycle after reset -> A acked first with cur_div=5. B acked at a later terminal edge with cur_div=6. The next simultaneous pair grants A first (pointer back at A).
4. req_b with div_b=1 -> ack_b and err high one edge later; cur_div unchanged; clk_en cadence unbroken. Same result for div_b=0.
5. Assert reset while in WAIT_TC with ratio 7 pending -> all outputs clear immediately without a clock edge; after release cur_div=3, busy=0, no ack.
6. req_a with div_a=255 (CNT_W=8) -> period becomes 255, clk_en spacing 255, div_out high 127 cycles. A following switch to 2 lands exactly at the terminal edge.
